// File: rtl/mem_seq_pkg.sv
// ---------------------------------------------------------------------------
// mem_seq_pkg
// Shared definitions for the memory-class instruction sequencer: the state
// enumeration (also exported on state_dbg), opcode encodings, the ALU add
// encoding and the default wait budget for the memory-ready handshake.
// ---------------------------------------------------------------------------
package mem_seq_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH0   = 4'd1,
      FETCH1   = 4'd2,
      FETCH_RD = 4'd3,
      FETCH2   = 4'd4,
      DECODE   = 4'd5,
      BASE     = 4'd6,
      ADDR     = 4'd7,
      LDI_WB   = 4'd8,
      MAR      = 4'd9,
      MEM_RD   = 4'd10,
      LD_WB    = 4'd11,
      ST_DATA  = 4'd12,
      MEM_WR   = 4'd13,
      END      = 4'd14
   } seqState_t;

   localparam int            OPCODE_W_DEF = 5;
   localparam int            ALU_OP_W_DEF = 4;
   localparam logic [3:0]    ALU_ADD_DEF  = 4'b0010;
   localparam logic [4:0]    OP_LD_DEF    = 5'b00000;
   localparam logic [4:0]    OP_LDI_DEF   = 5'b00001;
   localparam logic [4:0]    OP_ST_DEF    = 5'b00010;
   localparam int            WAIT_MAX_DEF = 15;

   // States in which the sequencer is stalled on the memory-ready handshake.
   function automatic logic isWaitState(input seqState_t s);
      return (s == FETCH_RD) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts stalled cycles while the sequencer waits for mem_ready and flags
// the cycle in which the wait budget runs out.
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   i_clear   : clear the counter (state change of the sequencer)
//   i_enable  : sequencer is in a wait state
//   i_ready   : mem_ready from memory
//   o_expire  : this cycle is the last allowed one and ready is still low
// ---------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   input  logic i_ready,
   output logic o_expire
);

   // Counter value seen during the final permitted wait cycle; ready in that
   // same cycle still wins over the timeout.
   localparam logic [7:0] LAST_COUNT = 8'(WAIT_MAX - 1);

   logic [7:0] r_count;

   // Stall counter: cleared whenever the sequencer changes state, so it
   // starts from zero on entry to each wait state and is left clean on exit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= 8'd0;
      end else if (i_clear) begin
         r_count <= 8'd0;
      end else if (i_enable && !i_ready) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign o_expire = i_enable && !i_ready && (r_count == LAST_COUNT);

endmodule

// File: rtl/mem_op_sequencer.sv
// ---------------------------------------------------------------------------
// mem_op_sequencer
// Hardwired control sequencer producing datapath strobes for instruction
// fetch and the ld / ldi / st instructions, with a memory-ready handshake,
// wait timeout, run/stop control and illegal-opcode detection.
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   run               : level, fetching continues while high (sampled in
//                       IDLE and END only)
//   ir                : instruction register, opcode in ir[31 -: OPCODE_W]
//   mem_ready         : memory completes the current read/write this cycle
//   pc_out .. ba_out  : datapath strobes
//   alu_op            : ALU operation select
//   done              : pulse on instruction completion
//   illegal           : registered pulse after decoding an unsupported opcode
//   mem_fault         : registered pulse after a mem_ready timeout
//   state_dbg         : current state encoding
// ---------------------------------------------------------------------------
module mem_op_sequencer
   import mem_seq_pkg::*;
#(
   parameter int                    OPCODE_W = OPCODE_W_DEF,
   parameter int                    ALU_OP_W = ALU_OP_W_DEF,
   parameter logic [ALU_OP_W-1:0]   ALU_ADD  = ALU_ADD_DEF,
   parameter logic [OPCODE_W-1:0]   OP_LD    = OP_LD_DEF,
   parameter logic [OPCODE_W-1:0]   OP_LDI   = OP_LDI_DEF,
   parameter logic [OPCODE_W-1:0]   OP_ST    = OP_ST_DEF,
   parameter int                    WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [31:0]         ir,
   input  logic                mem_ready,
   output logic                pc_out,
   output logic                pc_in,
   output logic                inc_pc,
   output logic                mar_in,
   output logic                mdr_in,
   output logic                mdr_out,
   output logic                read,
   output logic                write,
   output logic                ir_in,
   output logic                y_in,
   output logic                z_in,
   output logic                z_low_out,
   output logic                c_out,
   output logic                gra,
   output logic                grb,
   output logic                r_in,
   output logic                r_out,
   output logic                ba_out,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                done,
   output logic                illegal,
   output logic                mem_fault,
   output logic [3:0]          state_dbg
);

   seqState_t             r_state;
   seqState_t             w_nextState;
   logic                  r_isLd;
   logic                  r_isLdi;
   logic                  r_illegal;
   logic                  r_memFault;
   logic                  w_expire;
   logic [OPCODE_W-1:0]   w_opcode;
   logic                  w_legal;
   logic                  w_unusedIr;

   assign w_opcode   = ir[31 -: OPCODE_W];
   assign w_legal    = (w_opcode == OP_LD) || (w_opcode == OP_LDI) || (w_opcode == OP_ST);
   assign w_unusedIr = ^ir[31-OPCODE_W:0];

   // Wait budget shared by all three handshake states; any state change
   // clears it.
   mem_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_waitTimer (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_nextState != r_state),
      .i_enable (isWaitState(r_state)),
      .i_ready  (mem_ready),
      .o_expire (w_expire)
   );

   // State register plus the opcode class captured in DECODE (later branches
   // use the captured class so a changing ir cannot redirect the sequence).
   // The illegal and fault pulses are registered so they appear in the first
   // IDLE cycle after the aborting transition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_isLd     <= 1'b0;
         r_isLdi    <= 1'b0;
         r_illegal  <= 1'b0;
         r_memFault <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_illegal  <= (r_state == DECODE) && !w_legal;
         r_memFault <= w_expire;
         if (r_state == DECODE) begin
            r_isLd  <= (w_opcode == OP_LD);
            r_isLdi <= (w_opcode == OP_LDI);
         end
      end
   end

   // Next-state logic. A ready in a wait state always takes priority over
   // the timeout, so ready in the last budgeted cycle is a success.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:     if (run) w_nextState = FETCH0;
         FETCH0:   w_nextState = FETCH1;
         FETCH1:   w_nextState = FETCH_RD;
         FETCH_RD: begin
            if (mem_ready)     w_nextState = FETCH2;
            else if (w_expire) w_nextState = IDLE;
         end
         FETCH2:   w_nextState = DECODE;
         DECODE:   w_nextState = w_legal ? BASE : IDLE;
         BASE:     w_nextState = ADDR;
         ADDR:     w_nextState = r_isLdi ? LDI_WB : MAR;
         LDI_WB:   w_nextState = END;
         MAR:      w_nextState = r_isLd ? MEM_RD : ST_DATA;
         MEM_RD: begin
            if (mem_ready)     w_nextState = LD_WB;
            else if (w_expire) w_nextState = IDLE;
         end
         LD_WB:    w_nextState = END;
         ST_DATA:  w_nextState = MEM_WR;
         MEM_WR: begin
            if (mem_ready)     w_nextState = END;
            else if (w_expire) w_nextState = IDLE;
         end
         END:      w_nextState = run ? FETCH0 : IDLE;
         default:  w_nextState = IDLE;
      endcase
   end

   // Strobe decode from the current state. mdr_in in the read states and
   // done in MEM_WR follow mem_ready directly so the data latch and the
   // completion pulse line up with the memory's completion cycle.
   always_comb begin
      pc_out    = 1'b0;
      pc_in     = 1'b0;
      inc_pc    = 1'b0;
      mar_in    = 1'b0;
      mdr_in    = 1'b0;
      mdr_out   = 1'b0;
      read      = 1'b0;
      write     = 1'b0;
      ir_in     = 1'b0;
      y_in      = 1'b0;
      z_in      = 1'b0;
      z_low_out = 1'b0;
      c_out     = 1'b0;
      gra       = 1'b0;
      grb       = 1'b0;
      r_in      = 1'b0;
      r_out     = 1'b0;
      ba_out    = 1'b0;
      alu_op    = '0;
      done      = 1'b0;
      case (r_state)
         FETCH0: begin
            pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
            alu_op = ALU_ADD;
         end
         FETCH1:   begin z_low_out = 1'b1; pc_in = 1'b1; end
         FETCH_RD: begin read = 1'b1; mdr_in = mem_ready; end
         FETCH2:   begin mdr_out = 1'b1; ir_in = 1'b1; end
         BASE:     begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
         ADDR:     begin c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
         LDI_WB:   begin z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; done = 1'b1; end
         MAR:      begin z_low_out = 1'b1; mar_in = 1'b1; end
         MEM_RD:   begin read = 1'b1; mdr_in = mem_ready; end
         LD_WB:    begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; done = 1'b1; end
         ST_DATA:  begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
         MEM_WR:   begin write = 1'b1; done = mem_ready; end
         default:  begin end
      endcase
   end

   assign illegal   = r_illegal;
   assign mem_fault = r_memFault;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_op_sequencer
// Self-checking bench: directed steps followed by random instructions with
// random memory latencies, each compared against a cycle-count model of the
// instruction flow.
// ---------------------------------------------------------------------------
module tb_mem_op_sequencer;
   import mem_seq_pkg::*;

   localparam int WAIT_MAX = 15;

   logic        clk;
   logic        reset;
   logic        run;
   logic [31:0] ir;
   logic        mem_ready;
   logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write;
   logic        ir_in, y_in, z_in, z_low_out, c_out, gra, grb, r_in, r_out, ba_out;
   logic [3:0]  alu_op;
   logic        done, illegal, mem_fault;
   logic [3:0]  state_dbg;
   logic [28:0] allOut;

   int nAsserts;
   int nFails;

   int readCnt, writeCnt, doneCnt, illegalCnt, faultCnt, wbCnt, addCnt, overlapCnt, baseCnt;
   int termCycle;
   int accessIdx, accessCycles;
   bit inAccess;
   int delays [2];

   mem_op_sequencer #(
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .ir        (ir),
      .mem_ready (mem_ready),
      .pc_out    (pc_out),
      .pc_in     (pc_in),
      .inc_pc    (inc_pc),
      .mar_in    (mar_in),
      .mdr_in    (mdr_in),
      .mdr_out   (mdr_out),
      .read      (read),
      .write     (write),
      .ir_in     (ir_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .z_low_out (z_low_out),
      .c_out     (c_out),
      .gra       (gra),
      .grb       (grb),
      .r_in      (r_in),
      .r_out     (r_out),
      .ba_out    (ba_out),
      .alu_op    (alu_op),
      .done      (done),
      .illegal   (illegal),
      .mem_fault (mem_fault),
      .state_dbg (state_dbg)
   );

   assign allOut = {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write,
                    ir_in, y_in, z_in, z_low_out, c_out, gra, grb, r_in, r_out,
                    ba_out, alu_op, done, illegal, mem_fault, state_dbg};

   // Free-running clock, rising edges at 5, 15, 25 ns ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence itself stalls somewhere unexpected.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock cycle of the memory model and bookkeeping. At the falling
   // edge the memory looks at read/write and answers after the latency
   // chosen for the current access; outside accesses mem_ready is noise.
   task automatic applyStimulus(input int n);
      @(negedge clk);
      if (read || write) begin
         mem_ready = (accessCycles >= delays[accessIdx]);
         accessCycles++;
         inAccess = 1'b1;
      end else begin
         if (inAccess && accessIdx < 1) accessIdx++;
         inAccess     = 1'b0;
         accessCycles = 0;
         mem_ready    = 1'($urandom_range(0, 1));
      end
      #1;
      readCnt    += int'(read);
      writeCnt   += int'(write);
      doneCnt    += int'(done);
      illegalCnt += int'(illegal);
      faultCnt   += int'(mem_fault);
      wbCnt      += int'(gra && r_in);
      addCnt     += int'(alu_op == ALU_ADD_DEF);
      baseCnt    += int'(grb || ba_out);
      if ((int'(done) + int'(illegal) + int'(mem_fault)) > 1) overlapCnt++;
      if (termCycle == 0 && (done || illegal || mem_fault)) termCycle = n;
   endtask

   // Runs one instruction from IDLE and compares its externally visible
   // behaviour with cycle counts derived from the instruction flow:
   // 2 fetch set-up cycles, the fetch read, 2 decode cycles, 3 address
   // cycles, then the memory phase and write-back.
   task automatic runInstr(input string tag, input logic [31:0] irVal, input int df, input int dm);
      logic [4:0] op;
      bit fetchOk, memOk;
      int fc, mc, expTerm, expReads, expWrites, expDone, expIll, expFault, expWb, expAdd;
      op = irVal[31:27];
      delays[0] = df; delays[1] = dm;
      readCnt = 0; writeCnt = 0; doneCnt = 0; illegalCnt = 0; faultCnt = 0;
      wbCnt = 0; addCnt = 0; overlapCnt = 0; baseCnt = 0; termCycle = 0;
      accessIdx = 0; accessCycles = 0; inAccess = 1'b0;
      ir = irVal; run = 1'b1; mem_ready = 1'b0;
      for (int n = 1; n <= 80; n++) begin
         applyStimulus(n);
         if (n == 1) run = 1'b0;
         if (termCycle != 0 && n >= termCycle + 3) break;
      end

      fetchOk = (df < WAIT_MAX);
      fc      = fetchOk ? df + 1 : WAIT_MAX;
      memOk   = (dm < WAIT_MAX);
      mc      = memOk ? dm + 1 : WAIT_MAX;
      expReads = fc; expWrites = 0; expDone = 0; expIll = 0; expFault = 0; expWb = 0; expAdd = 2;
      if (!fetchOk) begin
         expTerm = 2 + WAIT_MAX + 1; expFault = 1; expAdd = 1;
      end else if (op != OP_LD_DEF && op != OP_LDI_DEF && op != OP_ST_DEF) begin
         expTerm = 2 + fc + 2 + 1; expIll = 1; expAdd = 1;
      end else if (op == OP_LDI_DEF) begin
         expTerm = 2 + fc + 2 + 3; expDone = 1; expWb = 1;
      end else if (op == OP_LD_DEF) begin
         expTerm = 2 + fc + 2 + 3 + mc + 1; expReads = fc + mc;
         expDone = memOk ? 1 : 0; expFault = memOk ? 0 : 1; expWb = memOk ? 1 : 0;
      end else begin
         expTerm = 2 + fc + 2 + 3 + 1 + mc + (memOk ? 0 : 1); expWrites = mc;
         expDone = memOk ? 1 : 0; expFault = memOk ? 0 : 1;
      end

      checkOutput({tag, ".termCycle"}, termCycle, expTerm);
      checkOutput({tag, ".readCycles"}, readCnt, expReads);
      checkOutput({tag, ".writeCycles"}, writeCnt, expWrites);
      checkOutput({tag, ".done"}, doneCnt, expDone);
      checkOutput({tag, ".illegal"}, illegalCnt, expIll);
      checkOutput({tag, ".memFault"}, faultCnt, expFault);
      checkOutput({tag, ".writeBack"}, wbCnt, expWb);
      checkOutput({tag, ".aluAdd"}, addCnt, expAdd);
      checkOutput({tag, ".pulseOverlap"}, overlapCnt, 0);
      checkOutput({tag, ".endIdle"}, 32'(state_dbg), 32'(IDLE));
      if (expIll == 1 || expFault == 1 && !fetchOk)
         checkOutput({tag, ".noBaseStrobes"}, baseCnt, 0);
   endtask

   function automatic int pickDelay();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)       return int'($urandom_range(0, 3));
      else if (r == 7) return WAIT_MAX - 1;
      else if (r == 8) return WAIT_MAX;
      else             return WAIT_MAX + 2;
   endfunction

   initial begin
      logic [31:0] irRand;
      logic [4:0]  opRand;
      int          sel;
      nAsserts = 0; nFails = 0;
      reset = 1'b1; run = 1'b0; ir = '0; mem_ready = 1'b0;
      delays[0] = 0; delays[1] = 0;

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset.allOutputs", 32'(allOut), 32'(IDLE));
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset.idleAfterRelease", 32'(state_dbg), 32'(IDLE));

      // Directed instructions, including timeout boundaries.
      runInstr("ld",          32'h0018_0000, 0, 0);
      runInstr("ldi",         32'h0810_0005, 0, 0);
      runInstr("st",          32'h1000_0123, 0, 3);
      runInstr("fetchTmo",    32'h0018_0000, WAIT_MAX, 0);
      runInstr("fetchLastOk", 32'h0018_0000, WAIT_MAX - 1, 0);
      runInstr("ldTmo",       32'h0018_0000, 1, WAIT_MAX);
      runInstr("stLastOk",    32'h1000_0000, 0, WAIT_MAX - 1);
      runInstr("stTmo",       32'h1000_0000, 2, WAIT_MAX);
      runInstr("illegal",     32'hF800_0000, 0, 0);

      // Illegal opcode with run held high: fetch restarts straight after.
      @(negedge clk);
      ir = 32'hF800_0000; run = 1'b1; mem_ready = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      checkOutput("illRun.pulse", 32'(illegal), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("illRun.refetch", 32'(state_dbg), 32'(FETCH0));
      run = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("illRun.drainIdle", 32'(state_dbg), 32'(IDLE));

      // Reset in the middle of a load's MEM_RD wait.
      ir = 32'h0018_0000; run = 1'b1; mem_ready = 1'b1;
      repeat (8) @(negedge clk);
      run = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("midReset.inMemRd", 32'(read), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midReset.allOutputs", 32'(allOut), 32'(IDLE));
      @(negedge clk);
      reset = 1'b0; run = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("midReset.resumeFetch", 32'(state_dbg), 32'(FETCH0));
      run = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("midReset.drainIdle", 32'(state_dbg), 32'(IDLE));

      // Random instruction mix with random memory latencies.
      for (int k = 0; k < 24; k++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       opRand = OP_LD_DEF;
            1:       opRand = OP_LDI_DEF;
            2:       opRand = OP_ST_DEF;
            default: opRand = 5'($urandom_range(3, 31));
         endcase
         irRand = {opRand, 27'($urandom)};
         runInstr($sformatf("rand%0d", k), irRand, pickDelay(), pickDelay());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
